serial_subtractor: RTL

Bit-serial WIDTH-bit subtractor computing y = a − b − borrow-in, one bit per clock, LSB first. It is the sequential, area-reduced inverse companion to the parallel `full_adder`. It serves datapaths where a multi-cycle subtract is acceptable, such as compare/decrement paths and divider prototypes. It uses a start/done handshake and holds its result stable until the next operation completes.

---
 rtl/serial_subtractor_pkg.sv | 18 +
 rtl/serial_subtractor_sub_bit.sv | 14 +
 rtl/serial_subtractor.sv | 128 ++++++++++++
 3 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and widths.
// Optional signed-overflow output is enabled with the SERIAL_SUB_OV_EN macro.
package serial_subtractor_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Signed overflow of a - b: operands of opposite sign and the result sign differs from a.
    function automatic logic sub_overflow(input logic a_msb, input logic b_msb, input logic y_msb);
        return (a_msb != b_msb) && (y_msb != a_msb);
    endfunction

endpackage

// File: rtl/serial_subtractor_sub_bit.sv
// Combinational 1-bit full subtractor: d = a - b - bw_in, with borrow-out.
// Used by serial_subtractor (optional SERIAL_SUB_OV_EN has no effect here).
module sub_bit (
    input  logic a,
    input  logic b,
    input  logic bw_in,
    output logic d,
    output logic bw_out
);

    assign d      = a ^ b ^ bw_in;
    assign bw_out = (~a & b) | (~(a ^ b) & bw_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor y = a - b - bw_i, LSB first, start/done handshake.
// Define SERIAL_SUB_OV_EN to add the registered signed-overflow output ov_o.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             bw_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] y_o,
`ifdef SERIAL_SUB_OV_EN
    output logic             ov_o,
`endif
    output logic             bw_o
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             bw_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_d;
    logic [WIDTH-1:0] y_q;
    logic             bwo_q;
    logic             busy_q;
    logic             done_q;
    logic             bit_d;
    logic             bit_bw;
`ifdef SERIAL_SUB_OV_EN
    logic             a_msb_q;
    logic             b_msb_q;
    logic             ov_q;
`endif

    sub_bit u_sub_bit (
        .a      (a_q[0]),
        .b      (b_q[0]),
        .bw_in  (bw_q),
        .d      (bit_d),
        .bw_out (bit_bw)
    );

    // The new difference bit enters at the MSB, so after WIDTH shifts the LSB lands at bit 0.
    assign res_d = {bit_d, res_q[WIDTH-1:1]};

    // NOTE: sequential state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            bw_q    <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            y_q     <= '0;
            bwo_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_SUB_OV_EN
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ov_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        a_q     <= a_i;
                        b_q     <= b_i;
                        bw_q    <= bw_i;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
`ifdef SERIAL_SUB_OV_EN
                        a_msb_q <= a_i[WIDTH-1];
                        b_msb_q <= b_i[WIDTH-1];
`endif
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SHIFT: begin
                    res_q <= res_d;
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    bw_q  <= bit_bw;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        y_q     <= res_d;
                        bwo_q   <= bit_bw;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
`ifdef SERIAL_SUB_OV_EN
                        ov_q    <= sub_overflow(a_msb_q, b_msb_q, bit_d);
`endif
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign y_o    = y_q;
    assign bw_o   = bwo_q;
`ifdef SERIAL_SUB_OV_EN
    assign ov_o   = ov_q;
`endif

endmodule
